crc_frame_ctrl: RTL and testbench

Frame-level controller that sequences the serial CRC engine (`CRC`: CLK, RST, ACTIVE, DATA, CRC, Valid).
- Accepts frame bytes over a valid/ready handshake and buffers one byte ahead.
- Clears the engine at frame start and streams each byte LSB-first with ACTIVE held continuously.
- Collects the serial CRC result into a parallel word and presents it downstream.
- Sits between the packet datapath and the CRC engine; the engine is instantiated beside it, not inside.

---
 rtl/crc_frame_ctrl_if.sv | 41 ++++
 rtl/crc_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_ctrl_if.sv
// Bus bundle between the frame controller, the packet datapath and the
// serial CRC engine. The master side is the controller itself; the slave
// side is whatever surrounds it (datapath, engine, result consumer).

interface crc_frame_ctrl_if #(
  parameter int CRC_W = 8
);

  // Frame byte stream from the packet datapath
  logic [7:0]       inData;
  logic             inLast;
  logic             inValid;
  logic             inReady;

  // Serial engine control and result
  logic             crcRstN;
  logic             crcActive;
  logic             crcData;
  logic             crcSer;
  logic             crcValid;

  // Collected result and error pulses
  logic [CRC_W-1:0] outCrc;
  logic             outValid;
  logic             outReady;
  logic             errUnderrun;
  logic             errTimeout;

  modport master (
    input  inData, inLast, inValid, crcSer, crcValid, outReady,
    output inReady, crcRstN, crcActive, crcData, outCrc, outValid,
           errUnderrun, errTimeout
  );

  modport slave (
    output inData, inLast, inValid, crcSer, crcValid, outReady,
    input  inReady, crcRstN, crcActive, crcData, outCrc, outValid,
           errUnderrun, errTimeout
  );

endinterface

// File: rtl/crc_frame_ctrl.sv
// Frame-level sequencer for an external serial CRC engine. Buffers one byte
// ahead, clears the engine at frame start, streams bytes LSB-first with the
// engine's ACTIVE held unbroken across byte boundaries, then gathers the
// engine's serial result into a parallel word held until downstream takes it.

module crc_frame_ctrl #(
  parameter int CRC_W   = 8,
  parameter int TIMEOUT = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  crc_frame_ctrl_if.master  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam int RC_W = $clog2(CRC_W + 1);
  localparam int TC_W = $clog2(TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       hbData_q, hbData_d;
  logic             hbLast_q, hbLast_d;
  logic             hbFull_q, hbFull_d;
  logic             lastPend_q, lastPend_d;
  logic [7:0]       srData_q, srData_d;
  logic             curLast_q, curLast_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [RC_W-1:0]  resCnt_q, resCnt_d;
  logic [TC_W-1:0]  toCnt_q, toCnt_d;
  logic [CRC_W-1:0] outCrc_q, outCrc_d;
  logic             errUnd_q, errUnd_d;
  logic             errTo_q, errTo_d;
  logic             accept;

  // Byte handshake: the holding register takes a byte only when empty and no
  // frame-ending byte is still waiting to be streamed
  always_comb begin
    bus.inReady = !hbFull_q && !lastPend_q && !rst_i;
    accept      = bus.inValid && bus.inReady;
  end

  // Engine-facing and downstream outputs, decoded from the current state
  always_comb begin
    bus.crcRstN     = !(rst_i || (state_q == CLEAR));
    bus.crcActive   = (state_q == SHIFT);
    bus.crcData     = (state_q == SHIFT) ? srData_q[bitCnt_q] : 1'b0;
    bus.outValid    = (state_q == HOLD);
    bus.outCrc      = outCrc_q;
    bus.errUnderrun = errUnd_q;
    bus.errTimeout  = errTo_q;
  end

  // Next-state logic for the frame sequencer and its buffers and counters
  always_comb begin
    state_d    = state_q;
    hbData_d   = hbData_q;
    hbLast_d   = hbLast_q;
    hbFull_d   = hbFull_q;
    lastPend_d = lastPend_q;
    srData_d   = srData_q;
    curLast_d  = curLast_q;
    bitCnt_d   = bitCnt_q;
    resCnt_d   = resCnt_q;
    toCnt_d    = toCnt_q;
    outCrc_d   = outCrc_q;
    errUnd_d   = 1'b0;
    errTo_d    = 1'b0;

    if (accept) begin
      hbData_d = bus.inData;
      hbLast_d = bus.inLast;
      hbFull_d = 1'b1;
      if (bus.inLast) lastPend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hbFull_q) state_d = CLEAR;
      end
      CLEAR: begin
        srData_d  = hbData_q;
        curLast_d = hbLast_q;
        hbFull_d  = 1'b0;
        bitCnt_d  = 3'd0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        bitCnt_d = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          if (curLast_q) begin
            state_d    = DRAIN;
            resCnt_d   = '0;
            toCnt_d    = '0;
            lastPend_d = 1'b0;
          end else if (hbFull_q) begin
            srData_d  = hbData_q;
            curLast_d = hbLast_q;
            hbFull_d  = 1'b0;
            bitCnt_d  = 3'd0;
          end else begin
            // A byte that arrives in this very cycle belongs to the aborted
            // frame, so it is dropped along with the partial frame
            state_d    = IDLE;
            errUnd_d   = 1'b1;
            lastPend_d = 1'b0;
            hbFull_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        toCnt_d = toCnt_q + TC_W'(1);
        if (bus.crcValid) begin
          for (int k = 0; k < CRC_W; k++) begin
            if (resCnt_q == RC_W'(k)) outCrc_d[k] = bus.crcSer;
          end
          resCnt_d = resCnt_q + RC_W'(1);
        end
        // A completed result wins over a timeout landing on the same cycle
        if (bus.crcValid && (resCnt_q == RC_W'(CRC_W - 1))) begin
          state_d = HOLD;
        end else if (toCnt_q == TC_W'(TIMEOUT - 1)) begin
          state_d  = IDLE;
          errTo_d  = 1'b1;
          outCrc_d = outCrc_q;
        end
      end
      HOLD: begin
        if (bus.outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      hbData_q   <= '0;
      hbLast_q   <= 1'b0;
      hbFull_q   <= 1'b0;
      lastPend_q <= 1'b0;
      srData_q   <= '0;
      curLast_q  <= 1'b0;
      bitCnt_q   <= '0;
      resCnt_q   <= '0;
      toCnt_q    <= '0;
      outCrc_q   <= '0;
      errUnd_q   <= 1'b0;
      errTo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hbData_q   <= hbData_d;
      hbLast_q   <= hbLast_d;
      hbFull_q   <= hbFull_d;
      lastPend_q <= lastPend_d;
      srData_q   <= srData_d;
      curLast_q  <= curLast_d;
      bitCnt_q   <= bitCnt_d;
      resCnt_q   <= resCnt_d;
      toCnt_q    <= toCnt_d;
      outCrc_q   <= outCrc_d;
      errUnd_q   <= errUnd_d;
      errTo_q    <= errTo_d;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl with a behavioural serial CRC-8 engine
// (poly 0x07, zero init, data bits fed in the order presented) beside it.

module tb_crc_frame_ctrl;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  crc_frame_ctrl_if #(.CRC_W(8)) bus ();

  crc_frame_ctrl #(.CRC_W(8), .TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial engine model: shifts while ACTIVE, then replays its register
  // LSB-first with Valid once ACTIVE drops, unless muted
  logic [7:0] engCrc;
  logic [2:0] engIdx;
  logic       engArmed;
  logic       engMute;

  assign bus.crcValid = engArmed && !bus.crcActive && !engMute;
  assign bus.crcSer   = engCrc[engIdx];

  always @(posedge clk) begin
    if (!bus.crcRstN) begin
      engCrc   <= 8'h00;
      engIdx   <= 3'd0;
      engArmed <= 1'b0;
    end else if (bus.crcActive) begin
      engCrc   <= {engCrc[6:0], 1'b0} ^ ((engCrc[7] ^ bus.crcData) ? 8'h07 : 8'h00);
      engIdx   <= 3'd0;
      engArmed <= 1'b1;
    end else if (bus.crcValid) begin
      engIdx <= engIdx + 3'd1;
      if (engIdx == 3'd7) engArmed <= 1'b0;
    end
  end

  // Observers for ACTIVE run length and accepted-byte count
  int   activeCycles;
  int   activeStarts;
  int   acceptCount;
  logic prevActive;

  initial begin
    activeCycles = 0;
    activeStarts = 0;
    acceptCount  = 0;
    prevActive   = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.crcActive) activeCycles++;
    if (bus.crcActive && !prevActive) activeStarts++;
    prevActive = bus.crcActive;
  end

  always @(posedge clk) begin
    if (bus.inValid && bus.inReady) acceptCount++;
  end

  function automatic logic [7:0] crcStep(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l);
    bus.inValid = v;
    bus.inData  = d;
    bus.inLast  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a byte, waits (bounded) for ready, lets the accepting edge pass
  task automatic sendByte(input logic [7:0] d, input logic l);
    applyStimulus(1'b1, d, l);
    for (int i = 0; i < 100; i++) begin
      if (bus.inReady) break;
      tick(1);
    end
    checkOutput("readyWait", {31'd0, bus.inReady}, 32'd1);
    tick(1);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitOutValid();
    for (int i = 0; i < 100; i++) begin
      if (bus.outValid) break;
      tick(1);
    end
    checkOutput("outValidWait", {31'd0, bus.outValid}, 32'd1);
  endtask

  task automatic takeResult();
    bus.outReady = 1'b1;
    tick(1);
    bus.outReady = 1'b0;
  endtask

  // Directed sequence covering reset, framing, errors and back-pressure
  initial begin
    logic [7:0] pat;
    logic [7:0] expCrc;
    logic       readySeen;
    int         actSnap;
    int         startSnap;
    int         accSnap;

    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    engMute = 1'b0;
    bus.outReady = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    tick(3);
    checkOutput("rstInReady", {31'd0, bus.inReady}, 32'd0);
    checkOutput("rstCrcRstN", {31'd0, bus.crcRstN}, 32'd0);
    checkOutput("rstOutCrc", {24'd0, bus.outCrc}, 32'd0);
    checkOutput("rstOutValid", {31'd0, bus.outValid}, 32'd0);
    checkOutput("rstActive", {31'd0, bus.crcActive}, 32'd0);
    rst = 1'b0;
    tick(1);
    checkOutput("postRstInReady", {31'd0, bus.inReady}, 32'd1);
    checkOutput("postRstCrcRstN", {31'd0, bus.crcRstN}, 32'd1);
    checkOutput("postRstErrs", {30'd0, bus.errUnderrun, bus.errTimeout}, 32'd0);

    // Single byte 0xA5: CRC-8/0x07 over bits 1,0,1,0,0,1,0,1 gives 0x72
    $display("[TB] single byte frame");
    sendByte(8'hA5, 1'b1);
    checkOutput("heldInReady", {31'd0, bus.inReady}, 32'd0);
    tick(1);
    checkOutput("clearRstN", {31'd0, bus.crcRstN}, 32'd0);
    checkOutput("clearActive", {31'd0, bus.crcActive}, 32'd0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checkOutput($sformatf("a5Active%0d", i), {31'd0, bus.crcActive}, 32'd1);
      checkOutput($sformatf("a5Bit%0d", i), {31'd0, bus.crcData}, {31'd0, pat[i]});
    end
    tick(1);
    checkOutput("drainActive", {31'd0, bus.crcActive}, 32'd0);
    checkOutput("drainRstN", {31'd0, bus.crcRstN}, 32'd1);
    tick(7);
    checkOutput("cycle17OutValid", {31'd0, bus.outValid}, 32'd0);
    tick(1);
    checkOutput("cycle18OutValid", {31'd0, bus.outValid}, 32'd1);
    checkOutput("a5Crc", {24'd0, bus.outCrc}, 32'h72);
    tick(3);
    checkOutput("holdOutValid", {31'd0, bus.outValid}, 32'd1);
    checkOutput("holdCrc", {24'd0, bus.outCrc}, 32'h72);
    takeResult();
    checkOutput("releasedOutValid", {31'd0, bus.outValid}, 32'd0);

    // Four bytes back-to-back: one unbroken 32-cycle ACTIVE run
    $display("[TB] four byte frame");
    actSnap = activeCycles;
    startSnap = activeStarts;
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h04, 1'b1);
    readySeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.crcActive) break;
      if (bus.inReady) readySeen = 1'b1;
      tick(1);
    end
    checkOutput("readyAfterLast", {31'd0, readySeen}, 32'd0);
    checkOutput("readyInDrain", {31'd0, bus.inReady}, 32'd1);
    waitOutValid();
    expCrc = crcStep(crcStep(crcStep(crcStep(8'h00, 8'h01), 8'h02), 8'h03), 8'h04);
    checkOutput("frame4Crc", {24'd0, bus.outCrc}, {24'd0, expCrc});
    checkOutput("frame4ActiveCycles", activeCycles - actSnap, 32'd32);
    checkOutput("frame4ActiveRuns", activeStarts - startSnap, 32'd1);
    takeResult();

    // Second byte withheld: underrun one cycle after the first byte's bit 7
    $display("[TB] underrun");
    sendByte(8'h11, 1'b0);
    tick(9);
    checkOutput("preUnderrun", {31'd0, bus.errUnderrun}, 32'd0);
    tick(1);
    checkOutput("underrunPulse", {31'd0, bus.errUnderrun}, 32'd1);
    checkOutput("underrunActive", {31'd0, bus.crcActive}, 32'd0);
    tick(1);
    checkOutput("underrunEnd", {31'd0, bus.errUnderrun}, 32'd0);
    checkOutput("underrunNoOut", {31'd0, bus.outValid}, 32'd0);
    tick(10);
    checkOutput("underrunStillNoOut", {31'd0, bus.outValid}, 32'd0);
    sendByte(8'hFF, 1'b1);
    waitOutValid();
    expCrc = crcStep(8'h00, 8'hFF);
    checkOutput("ffCrc", {24'd0, bus.outCrc}, {24'd0, expCrc});
    takeResult();

    // Engine never answers: timeout 16 cycles after DRAIN entry (cycle 10)
    $display("[TB] timeout");
    engMute = 1'b1;
    sendByte(8'h5A, 1'b1);
    tick(25);
    checkOutput("preTimeout", {31'd0, bus.errTimeout}, 32'd0);
    tick(1);
    checkOutput("timeoutPulse", {31'd0, bus.errTimeout}, 32'd1);
    checkOutput("timeoutNoOut", {31'd0, bus.outValid}, 32'd0);
    checkOutput("timeoutNoUnderrun", {31'd0, bus.errUnderrun}, 32'd0);
    checkOutput("timeoutCrcKept", {24'd0, bus.outCrc}, {24'd0, expCrc});
    tick(1);
    checkOutput("timeoutEnd", {31'd0, bus.errTimeout}, 32'd0);
    checkOutput("timeoutIdleReady", {31'd0, bus.inReady}, 32'd1);
    engMute = 1'b0;

    // Result held under back-pressure while the next frame's byte waits
    $display("[TB] back-pressure");
    sendByte(8'h77, 1'b1);
    waitOutValid();
    expCrc = crcStep(8'h00, 8'h77);
    accSnap = acceptCount;
    applyStimulus(1'b1, 8'h3C, 1'b1);
    tick(10);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("bpAcceptOnce", acceptCount - accSnap, 32'd1);
    checkOutput("bpOutValid", {31'd0, bus.outValid}, 32'd1);
    checkOutput("bpCrcStable", {24'd0, bus.outCrc}, {24'd0, expCrc});
    takeResult();
    checkOutput("bpIdleRstN", {31'd0, bus.crcRstN}, 32'd1);
    tick(1);
    checkOutput("bpClearRstN", {31'd0, bus.crcRstN}, 32'd0);
    waitOutValid();
    expCrc = crcStep(8'h00, 8'h3C);
    checkOutput("x3cCrc", {24'd0, bus.outCrc}, {24'd0, expCrc});
    takeResult();

    // Reset in SHIFT at bit 3, then a clean frame
    $display("[TB] reset mid-frame");
    sendByte(8'h96, 1'b1);
    tick(5);
    checkOutput("bit3Active", {31'd0, bus.crcActive}, 32'd1);
    rst = 1'b1;
    tick(1);
    checkOutput("midRstRstN", {31'd0, bus.crcRstN}, 32'd0);
    checkOutput("midRstReady", {31'd0, bus.inReady}, 32'd0);
    checkOutput("midRstActive", {31'd0, bus.crcActive}, 32'd0);
    checkOutput("midRstData", {31'd0, bus.crcData}, 32'd0);
    checkOutput("midRstOutValid", {31'd0, bus.outValid}, 32'd0);
    checkOutput("midRstOutCrc", {24'd0, bus.outCrc}, 32'd0);
    checkOutput("midRstErrs", {30'd0, bus.errUnderrun, bus.errTimeout}, 32'd0);
    rst = 1'b0;
    tick(12);
    checkOutput("afterRstIdle", {31'd0, bus.crcActive}, 32'd0);
    checkOutput("afterRstNoErr", {30'd0, bus.errUnderrun, bus.errTimeout}, 32'd0);
    sendByte(8'hC3, 1'b1);
    waitOutValid();
    expCrc = crcStep(8'h00, 8'hC3);
    checkOutput("c3Crc", {24'd0, bus.outCrc}, {24'd0, expCrc});
    takeResult();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
